// File: rtl/mlp_host_ctrl_pkg.sv
// Shared constants, opcodes and sequencer states for the MLP host-side controller.
package mlp_pkg;
  localparam int DataWidth   = 16;
  localparam int NumLayers   = 8;
  localparam int Dim         = 16;
  localparam int WeightWords = NumLayers * Dim * Dim;
  localparam int XWords      = Dim * Dim;
  localparam int FifoDepth   = 256;

  // Bit positions inside err_o
  localparam int ErrUnderrun    = 0;
  localparam int ErrUnexpResult = 1;

  typedef enum logic {
    OpLoadW = 1'b0,
    OpInfer = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StInitReq,
    StStreamW,
    StStartReq,
    StStreamX,
    StCollect
  } host_state_e;
endpackage

// File: rtl/mlp_host_ctrl_if.sv
// Accelerator-facing control/data bundle; names are seen from the host side.
interface mlp_host_ctrl_if #(
  parameter int DataWidth = 16
);
  logic                 init_valid_o;
  logic                 init_ready_i;
  logic                 start_valid_o;
  logic                 start_ready_i;
  logic [DataWidth-1:0] load_payload_o;
  logic                 result_valid_i;
  logic [DataWidth-1:0] result_data_i;

  modport master (
    output init_valid_o, start_valid_o, load_payload_o,
    input  init_ready_i, start_ready_i, result_valid_i, result_data_i
  );

  modport slave (
    input  init_valid_o, start_valid_o, load_payload_o,
    output init_ready_i, start_ready_i, result_valid_i, result_data_i
  );
endinterface

// File: rtl/mlp_host_ctrl_fifo.sv
// First-word-fall-through result FIFO; the head entry is visible while not empty.
module mlp_result_fifo #(
  parameter int Width = 17,
  parameter int Depth = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
    if (do_pop) rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/mlp_host_ctrl.sv
// Host-side sequencer: issues init/start, streams weight/activation bursts, collects results.
module mlp_host_ctrl import mlp_pkg::*; #(
  parameter int DataWidth = mlp_pkg::DataWidth,
  parameter int NumLayers = mlp_pkg::NumLayers,
  parameter int Dim       = mlp_pkg::Dim,
  parameter int FifoDepth = mlp_pkg::FifoDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_op_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  mlp_host_ctrl_if.master      acc_if,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  output logic [1:0]           err_o,
  output logic                 busy_o
);
  localparam int WWords = NumLayers * Dim * Dim;
  localparam int XW     = Dim * Dim;
  localparam int CntW   = $clog2(WWords);
  localparam logic [CntW-1:0] WLast = CntW'(WWords - 1);
  localparam logic [CntW-1:0] XLast = CntW'(XW - 1);

  host_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           err_q, err_d;
  logic [DataWidth-1:0] payload;
  logic                 init_valid, start_valid;
  logic                 push, push_last, fifo_empty, fifo_pop;
  logic [DataWidth:0]   fifo_head;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    payload     = '0;
    init_valid  = 1'b0;
    start_valid = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    case (state_q)
      StIdle: begin
        // Infer must only start into an empty FIFO, so gate every command on it.
        cmd_ready_o = fifo_empty;
        if (cmd_valid_i && fifo_empty) begin
          err_d   = '0;
          cnt_d   = '0;
          state_d = (op_e'(cmd_op_i) == OpInfer) ? StStartReq : StInitReq;
        end
      end
      StInitReq: begin
        init_valid = 1'b1;
        if (acc_if.init_ready_i) state_d = StStreamW;
      end
      StStartReq: begin
        start_valid = 1'b1;
        if (acc_if.start_ready_i) state_d = StStreamX;
      end
      StStreamW, StStreamX: begin
        // The accelerator cannot stall, so a missing word becomes a zero plus a sticky flag.
        in_ready_o = 1'b1;
        if (in_valid_i) payload = in_data_i;
        else            err_d[ErrUnderrun] = 1'b1;
        if (cnt_q == ((state_q == StStreamW) ? WLast : XLast)) begin
          cnt_d   = '0;
          state_d = (state_q == StStreamW) ? StIdle : StCollect;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCollect: begin
        if (acc_if.result_valid_i) begin
          push      = 1'b1;
          push_last = (cnt_q == XLast);
          if (push_last) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (acc_if.result_valid_i && (state_q != StCollect)) err_d[ErrUnexpResult] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  mlp_result_fifo #(
    .Width (DataWidth + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i ({push_last, acc_if.result_data_i}),
    .pop_i       (fifo_pop),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign fifo_pop              = !fifo_empty && out_ready_i;
  assign out_valid_o           = !fifo_empty;
  assign out_data_o            = fifo_empty ? '0 : fifo_head[DataWidth-1:0];
  assign out_last_o            = !fifo_empty && fifo_head[DataWidth];
  assign acc_if.init_valid_o   = init_valid;
  assign acc_if.start_valid_o  = start_valid;
  assign acc_if.load_payload_o = payload;
  assign err_o                 = err_q;
  assign busy_o                = (state_q != StIdle);
endmodule
